// File: rtl/matrix_pkg.sv
// ---------------------------------------------------------------------------
// matrix_pkg
//   Definitions shared by the matrix multiplier and its result collector.
//   - DEF_M / DEF_W : default matrix dimension and data word width.
//   - idx_w()       : index width for a given count, clog2 with a minimum of 1.
//   - wr_state_t    : encoding of the collector's write FSM.
// ---------------------------------------------------------------------------
package matrix_pkg;

  localparam int DEF_M = 4;
  localparam int DEF_W = 32;

  // Index width for n items. A single-entry dimension still needs one bit
  // so that the index ports never collapse to zero width.
  function automatic int idx_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  typedef enum logic [1:0] {
    S_RECV = 2'd0,
    S_ACK  = 2'd1,
    S_DROP = 2'd2
  } wr_state_t;

endpackage

// File: rtl/result_ram.sv
// ---------------------------------------------------------------------------
// result_ram
//   M*M x W storage for the result matrix. One write port and one registered
//   read port, both addressed by (row, column). Out-of-range indices, which
//   can occur when M is not a power of two, are filtered on both ports: a
//   write is dropped and a read returns zero.
//
// Ports
//   clk      : clock, rising edge.
//   rst      : synchronous active-low reset; clears the read register only.
//   we       : write enable.
//   wr_i/j   : write row / column.
//   wr_data  : write word.
//   re       : read enable; rd_data/rd_valid update on the next edge.
//   rd_i/j   : read row / column.
//   rd_data  : registered read word (holds when re is low).
//   rd_valid : one-cycle pulse accompanying a read.
// ---------------------------------------------------------------------------
module result_ram
  import matrix_pkg::*;
#(
  parameter int M     = DEF_M,
  parameter int W     = DEF_W,
  parameter int IDX_W = idx_w(M),
  parameter int AW    = idx_w(M * M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_i,
  input  logic [IDX_W-1:0] wr_j,
  input  logic [W-1:0]     wr_data,
  input  logic             re,
  input  logic [IDX_W-1:0] rd_i,
  input  logic [IDX_W-1:0] rd_j,
  output logic [W-1:0]     rd_data,
  output logic             rd_valid
);

  logic [W-1:0] mem [M*M];

  function automatic logic in_range(input logic [IDX_W-1:0] i,
                                    input logic [IDX_W-1:0] j);
    return (int'(i) < M) && (int'(j) < M);
  endfunction

  // Row-major linear address i*M + j.
  function automatic logic [AW-1:0] addr_of(input logic [IDX_W-1:0] i,
                                            input logic [IDX_W-1:0] j);
    return AW'(int'(i) * M + int'(j));
  endfunction

  logic wr_ok;
  logic rd_ok;

  assign wr_ok = we && in_range(wr_i, wr_j);
  assign rd_ok = in_range(rd_i, rd_j);

  // Storage has no reset: the result matrix survives reset and clear.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[addr_of(wr_i, wr_j)] <= wr_data;
    end
  end

  // Read register. A same-cycle write to the read address lands after this
  // sample, so the read returns the pre-write word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= re;
      if (re) begin
        rd_data <= rd_ok ? mem[addr_of(rd_i, rd_j)] : '0;
      end
    end
  end

endmodule

// File: rtl/matrix_result_collector.sv
// ---------------------------------------------------------------------------
// matrix_result_collector
//   Sink for the matrix multiplier's result stream. Each (z_in, z_i, z_j)
//   strobe is written into an M*M result store; later strobes to the same
//   (i,j) overwrite earlier ones, so the last partial sum per element is the
//   final C value. After the multiplier's done pulse the matrix is marked
//   complete and random-access reads are served from the store.
//
// Ports
//   clk, rst    : clock and synchronous active-low reset.
//   z_in        : result word from the multiplier.
//   z_i, z_j    : row / column of z_in.
//   z_stb       : result valid, held by the source until it sees z_ack.
//   z_ack       : one-cycle acknowledge.
//   mul_done    : one-cycle completion pulse from the multiplier.
//   clear       : start a new collection (drops complete, zeroes wr_count).
//   complete    : result matrix valid, reads enabled.
//   wr_count    : accepted strobes since clear/reset, saturating.
//   rd_req      : read request (honoured only while complete).
//   rd_i, rd_j  : read row / column.
//   rd_data     : registered read word.
//   rd_valid    : one-cycle pulse, rd_data valid.
//   fsm_state   : current write FSM state, for observation.
//
// Handshake: the source raises z_stb with stable z_in/z_i/z_j and holds them
// until it observes z_ack. A capture happens on the first edge that samples
// z_stb high in S_RECV; z_ack is high for exactly the following cycle. The
// source must then drop z_stb, and no new capture is taken until z_stb has
// been sampled low, so a strobe that is retired late is never written twice.
// ---------------------------------------------------------------------------
module matrix_result_collector
  import matrix_pkg::*;
#(
  parameter int M     = DEF_M,
  parameter int W     = DEF_W,
  parameter int IDX_W = idx_w(M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     z_in,
  input  logic [IDX_W-1:0] z_i,
  input  logic [IDX_W-1:0] z_j,
  input  logic             z_stb,
  output logic             z_ack,
  input  logic             mul_done,
  input  logic             clear,
  output logic             complete,
  output logic [15:0]      wr_count,
  input  logic             rd_req,
  input  logic [IDX_W-1:0] rd_i,
  input  logic [IDX_W-1:0] rd_j,
  output logic [W-1:0]     rd_data,
  output logic             rd_valid,
  output wr_state_t        fsm_state
);

  wr_state_t state;
  logic      capture;
  logic      rd_en;

  assign capture   = (state == S_RECV) && z_stb;
  assign rd_en     = rd_req && complete;
  assign fsm_state = state;

  // Write FSM, strobe counter and completion flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_RECV;
      z_ack    <= 1'b0;
      complete <= 1'b0;
      wr_count <= '0;
    end else begin
      case (state)
        S_RECV: begin
          z_ack <= 1'b0;
          if (z_stb) begin
            z_ack <= 1'b1;
            state <= S_ACK;
          end
        end
        S_ACK: begin
          z_ack <= 1'b0;
          state <= S_DROP;
        end
        S_DROP: begin
          z_ack <= 1'b0;
          if (!z_stb) begin
            state <= S_RECV;
          end
        end
        default: begin
          z_ack <= 1'b0;
          state <= S_RECV;
        end
      endcase

      // clear dominates mul_done. A capture in the clear cycle still counts,
      // so the new collection starts at one.
      if (clear) begin
        complete <= 1'b0;
        wr_count <= capture ? 16'd1 : 16'd0;
      end else begin
        if (mul_done) begin
          complete <= 1'b1;
        end
        if (capture && (wr_count != 16'hFFFF)) begin
          wr_count <= wr_count + 16'd1;
        end
      end
    end
  end

  // The write is gated by rst so a strobe sampled during reset is not stored.
  result_ram #(
    .M    (M),
    .W    (W),
    .IDX_W(IDX_W),
    .AW   (idx_w(M * M))
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (capture && rst),
    .wr_i    (z_i),
    .wr_j    (z_j),
    .wr_data (z_in),
    .re      (rd_en),
    .rd_i    (rd_i),
    .rd_j    (rd_j),
    .rd_data (rd_data),
    .rd_valid(rd_valid)
  );

endmodule

// File: tb/tb_matrix_result_collector.sv
module tb_matrix_result_collector;
  import matrix_pkg::*;

  localparam int M     = 4;
  localparam int W     = 32;
  localparam int IDX_W = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [W-1:0]     z_in;
  logic [IDX_W-1:0] z_i, z_j;
  logic             z_stb;
  logic             z_ack;
  logic             mul_done;
  logic             clear;
  logic             complete;
  logic [15:0]      wr_count;
  logic             rd_req;
  logic [IDX_W-1:0] rd_i, rd_j;
  logic [W-1:0]     rd_data;
  logic             rd_valid;
  wr_state_t        fsm_state;

  matrix_result_collector #(.M(M), .W(W), .IDX_W(IDX_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .z_in     (z_in),
    .z_i      (z_i),
    .z_j      (z_j),
    .z_stb    (z_stb),
    .z_ack    (z_ack),
    .mul_done (mul_done),
    .clear    (clear),
    .complete (complete),
    .wr_count (wr_count),
    .rd_req   (rd_req),
    .rd_i     (rd_i),
    .rd_j     (rd_j),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int failed    = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_mem [M*M];
  int rv_run = 0;
  int rv_max = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Read monitor: every rd_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rst && rd_valid) begin
      rv_run++;
      if (rv_run > rv_max) rv_max = rv_run;
      if (exp_q.size() == 0) check("rd_unexpected", rd_valid, 1'b0);
      else check("rd_data", rd_data, exp_q.pop_front());
    end else begin
      rv_run = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int i, input int j, input logic [W-1:0] d);
    int n;
    n = 0;
    z_i = IDX_W'(i); z_j = IDX_W'(j); z_in = d; z_stb = 1'b1;
    model_mem[i*M+j] = d;
    do begin @(negedge clk); n++; end while (!z_ack && n < 8);
    check("ack_latency", n, 1);
    z_stb = 1'b0;
    @(negedge clk);
    check("ack_width", z_ack, 1'b0);
    @(negedge clk);
  endtask

  task automatic pulse_done();
    mul_done = 1'b1;
    @(negedge clk);
    mul_done = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Issues a read while complete is expected high; rd_req is left asserted
  // so callers can chain reads back-to-back.
  task automatic issue_read(input int i, input int j);
    rd_i = IDX_W'(i); rd_j = IDX_W'(j); rd_req = 1'b1;
    exp_q.push_back(model_mem[i*M+j]);
    @(negedge clk);
  endtask

  task automatic drain_reads();
    int n;
    rd_req = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 6) begin @(negedge clk); n++; end
    check("rd_drain", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acks;
    logic [W-1:0] old_w;
    rst = 1'b0; z_in = '0; z_i = '0; z_j = '0; z_stb = 1'b0;
    mul_done = 1'b0; clear = 1'b0; rd_req = 1'b0; rd_i = '0; rd_j = '0;
    for (int a = 0; a < M*M; a++) model_mem[a] = '0;
    repeat (3) @(negedge clk);
    check("rst_z_ack", z_ack, 1'b0);
    check("rst_complete", complete, 1'b0);
    check("rst_wr_count", wr_count, 16'd0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_state", fsm_state, S_RECV);
    rst = 1'b1;
    @(negedge clk);

    // Basic handshake, plus a read attempted before completion.
    send(1, 2, 32'h3F800000);
    rd_i = 2'd1; rd_j = 2'd2; rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    check("gated_rd_valid", rd_valid, 1'b0);
    check("gated_rd_data", rd_data, 32'd0);
    pulse_done();
    check("basic_complete", complete, 1'b1);
    issue_read(1, 2);
    drain_reads();
    check("basic_wr_count", wr_count, 16'd1);

    // Clear after completion.
    pulse_clear();
    check("clear_complete", complete, 1'b0);
    check("clear_wr_count", wr_count, 16'd0);

    // Overwrite semantics.
    send(0, 0, 32'h3F800000);
    send(0, 0, 32'h40000000);
    send(0, 0, 32'h40400000);
    send(0, 0, 32'h40800000);
    pulse_done();
    check("ovw_wr_count", wr_count, 16'd4);
    issue_read(0, 0);
    drain_reads();
    check("ovw_model", model_mem[0], 32'h40800000);

    // Full run: 64 strobes, k fastest, then 16 back-to-back reads.
    pulse_clear();
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        for (int k = 0; k < M; k++)
          send(i, j, 32'(i*256 + j*16 + k));
    pulse_done();
    check("full_wr_count", wr_count, 16'd64);
    rv_max = 0;
    for (int a = 0; a < M*M; a++) issue_read(a / M, a % M);
    drain_reads();
    check("full_rd_burst", rv_max, 16);

    // clear and mul_done together: clear wins.
    pulse_clear();
    clear = 1'b1; mul_done = 1'b1;
    @(negedge clk);
    clear = 1'b0; mul_done = 1'b0;
    check("clr_vs_done", complete, 1'b0);

    // Held strobe: five cycles high yields exactly one capture.
    acks = 0;
    z_i = 2'd2; z_j = 2'd2; z_in = 32'hA5A5_0001; z_stb = 1'b1;
    model_mem[2*M+2] = 32'hA5A5_0001;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (z_ack) acks++;
    end
    check("held_acks", acks, 1);
    check("held_wr_count", wr_count, 16'd1);
    check("held_state", fsm_state, S_DROP);
    z_stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    send(2, 2, 32'h5A5A_0002);
    check("held_wr_count2", wr_count, 16'd2);
    pulse_done();
    issue_read(2, 2);
    drain_reads();

    // Same-cycle write and read of one address returns the old word.
    old_w = model_mem[3*M+3];
    exp_q.push_back(old_w);
    z_i = 2'd3; z_j = 2'd3; z_in = 32'hC0FF_EE00; z_stb = 1'b1;
    rd_i = 2'd3; rd_j = 2'd3; rd_req = 1'b1;
    model_mem[3*M+3] = 32'hC0FF_EE00;
    @(negedge clk);
    rd_req = 1'b0;
    check("rw_ack", z_ack, 1'b1);
    check("rw_complete", complete, 1'b1);
    z_stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    drain_reads();
    issue_read(3, 3);
    drain_reads();

    // Reset during the acknowledge cycle.
    z_i = 2'd1; z_j = 2'd1; z_in = 32'h1234_5678; z_stb = 1'b1;
    @(negedge clk);
    check("mid_ack_seen", z_ack, 1'b1);
    rst = 1'b0; z_stb = 1'b0;
    @(negedge clk);
    check("mid_rst_ack", z_ack, 1'b0);
    check("mid_rst_complete", complete, 1'b0);
    check("mid_rst_wr_count", wr_count, 16'd0);
    rst = 1'b1;
    @(negedge clk);
    send(1, 1, 32'h8765_4321);
    check("post_rst_wr_count", wr_count, 16'd1);
    pulse_done();
    issue_read(1, 1);
    drain_reads();

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/matrix_result_collector.md
Name: matrix_result_collector

Overview:
- Sink end of the matrix-multiplier result stream. Accepts each (z_out, z_i, z_j) strobe with the z_stb/z_ack handshake and writes the word into an M×M result store.
- The multiplier emits one partial sum per k, so later writes to the same (i,j) overwrite earlier ones. The last value written per (i,j) is the final C element.
- After the multiplier's done pulse, the block serves registered random-access reads of C to downstream logic (readback/DMA).

Parameters:
- M, 4, matrix dimension; the store holds M*M words.
- W, 32, data word width.
- IDX_W, max(1, clog2(M)), row/column index width; must match the multiplier index ports.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  synchronous active-low reset; sampled on the rising edge of clk.
- z_in  in  W  result word from the multiplier (its z_out).
- z_i  in  IDX_W  row index of z_in.
- z_j  in  IDX_W  column index of z_in.
- z_stb  in  1  result-valid strobe; held high by the source until it sees z_ack.
- z_ack  out  1  one-cycle acknowledge.
- mul_done  in  1  one-cycle completion pulse from the multiplier.
- clear  in  1  starts a new collection.
- complete  out  1  result matrix valid, reads enabled.
- wr_count  out  16  accepted strobes since the last clear/reset; saturates at 16'hFFFF.
- rd_req  in  1  read request.
- rd_i  in  IDX_W  read row index.
- rd_j  in  IDX_W  read column index.
- rd_data  out  W  read data.
- rd_valid  out  1  one-cycle pulse, rd_data valid.

Behaviour:
- Reset (rst==0 at a clk edge): state=S_RECV; z_ack=0, complete=0, wr_count=0, rd_data=0, rd_valid=0. Store contents are not cleared.
- Reset mid-handshake: drops z_ack on the next edge; no write is performed that cycle.
- Write FSM states:
  - S_RECV: at an edge with z_stb=1, write mem[z_i*M+z_j] <= z_in, set z_ack<=1, increment wr_count, go to S_ACK.
  - S_ACK: z_ack is high for exactly this cycle. Next edge: z_ack<=0, go to S_DROP.
  - S_DROP: stay until z_stb is sampled 0, then go to S_RECV. This prevents a double capture while the source retires its strobe.
- Write throughput: at most one write per 3 cycles. Latency is 1 cycle from z_stb sampled high to z_ack high.
- Out-of-range write index (z_i>=M or z_j>=M, possible when M is not a power of two): the handshake completes normally, wr_count increments, and the store is not written.
- complete:
  - Set to 1 on the edge after mul_done=1.
  - Cleared to 0 by clear=1; this also zeroes wr_count.
  - clear and mul_done in the same cycle: clear wins.
  - clear in S_ACK or S_DROP: the handshake still finishes; wr_count restarts at 0, or at 1 if a capture happens in the same cycle.
- Strobes while complete=1: accepted and written. complete stays 1, because the source has started a new run without clear.
- Read port:
  - rd_req=1 with complete=1: the next edge loads rd_data<=mem[rd_i*M+rd_j] and pulses rd_valid for 1 cycle.
  - Reads may be issued back-to-back, one per cycle.
  - rd_req with complete=0: ignored; rd_valid stays 0 and rd_data holds its value.
  - Out-of-range read index: rd_data=0, rd_valid=1.
- Same-cycle write and read of the same address: the read returns the old (pre-write) word.
- Index arithmetic: address = z_i*M + z_j, width clog2(M*M).

Decomposition:
- Shared package (matrix_pkg):
  - IDX_W function (clog2 with minimum 1).
  - Write FSM state encodings S_RECV=2'd0, S_ACK=2'd1, S_DROP=2'd2.
  - Default M and W constants, shared with the multiplier.
- One sub-module: result_ram. It is a one-write, one-registered-read, M*M×W storage array with an in-range check on both ports.
- The FSM, counters and flags stay in the top level.

Test Plan:
- Basic handshake: after reset, drive z_stb=1, z_i=1, z_j=2, z_in=32'h3F800000 and hold until z_ack.
  - z_ack is high exactly one cycle, at the cycle after the first sample.
  - Then drop z_stb, pulse mul_done, and read (1,2): rd_valid one cycle later, rd_data=32'h3F800000, wr_count=1.
- Overwrite semantics: four strobes to (0,0) with 1.0, 2.0, 3.0, 4.0 (32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000), then mul_done.
  - Read (0,0) returns 32'h40800000; wr_count=4.
- Full M=4 run: 64 strobes, k-fastest, with z_in = {i,j,k} encoded; then mul_done.
  - Read all 16 entries back-to-back: entry (i,j) equals its k=3 value, rd_valid is high 16 consecutive cycles, wr_count=64.
- Held strobe: z_stb kept high 5 cycles.
  - Exactly one write and one z_ack pulse; wr_count=1; the next write is accepted only after z_stb is seen low.
- Read gating and clear:
  - rd_req before mul_done: rd_valid=0.
  - clear and mul_done in the same cycle: complete stays 0.
  - clear after complete: complete=0 and wr_count=0 next cycle.
- Reset mid-handshake: assert rst=0 during the S_ACK cycle.
  - Next edge: z_ack=0, complete=0, wr_count=0.
  - After release, a fresh strobe is accepted normally.
